// File: rtl/nn_ctrl_pkg.sv
// nn_ctrl_pkg: shared constants and types for the CNN inference controller.
//   - register selects (bus_addr[4:2])
//   - nn_arg command-word bit positions
//   - CTRL and STATUS field positions
//   - FSM state enum and a helper that builds the nn_arg word
package nn_ctrl_pkg;

  // Register selects, i.e. byte offset >> 2
  localparam logic [2:0] REG_CTRL      = 3'd0;
  localparam logic [2:0] REG_PERIOD    = 3'd1;
  localparam logic [2:0] REG_TIMEOUT   = 3'd2;
  localparam logic [2:0] REG_STATUS    = 3'd3;
  localparam logic [2:0] REG_RESULT    = 3'd4;
  localparam logic [2:0] REG_LAST      = 3'd5;
  localparam logic [2:0] REG_INFER_CNT = 3'd6;
  localparam logic [2:0] REG_CLEAR     = 3'd7;

  // nn_arg bit positions
  localparam int unsigned ARG_WE     = 0;
  localparam int unsigned ARG_START  = 1;
  localparam int unsigned ARG_RESIZE = 2;
  localparam int unsigned ARG_BIN    = 3;

  // CTRL bit positions
  localparam int unsigned CTRL_AUTO    = 0;
  localparam int unsigned CTRL_ONESHOT = 1;
  localparam int unsigned CTRL_RESIZE  = 2;
  localparam int unsigned CTRL_BIN     = 3;

  // STATUS field positions
  localparam int unsigned ST_BUSY    = 0;
  localparam int unsigned ST_EMPTY   = 1;
  localparam int unsigned ST_FULL    = 2;
  localparam int unsigned ST_OVF     = 3;
  localparam int unsigned ST_UFL     = 4;
  localparam int unsigned ST_CNT_LSB = 8;
  localparam int unsigned ST_TMO_LSB = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_GAP
  } nn_state_e;

  function automatic logic [31:0] arg_word(input logic bin, input logic resize,
                                           input logic start, input logic we);
    logic [31:0] w;
    w             = '0;
    w[ARG_WE]     = we;
    w[ARG_START]  = start;
    w[ARG_RESIZE] = resize;
    w[ARG_BIN]    = bin;
    return w;
  endfunction

endpackage

// File: rtl/nn_result_fifo.sv
// nn_result_fifo: synchronous FIFO for CNN results.
//   clk, rst        : clock, synchronous active-high reset (flushes the FIFO)
//   push, push_data : write request; ignored when full unless a pop happens the same cycle
//   pop, pop_data   : read request; pop_data shows the head entry (first-word fall-through)
//   full, empty     : occupancy flags
//   count           : number of stored entries
module nn_result_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign do_pop   = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/nn_infer_ctrl.sv
// nn_infer_ctrl: host-side controller for the quantized-CNN wrapper.
//   CLK, RST  : clock, synchronous active-high reset
//   bus_*     : word-addressed register port (bus_rdata valid one cycle after bus_re)
//   nn_arg    : registered command word [0]=WE [1]=start [2]=resize [3]=binarize
//   nn_data   : prediction from the wrapper, qualified by the one-cycle nn_en strobe
//   busy      : FSM is not idle
// Runs single-shot or periodic inferences with optional timeout/retry and buffers
// results in a small FIFO.
module nn_infer_ctrl
  import nn_ctrl_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = 32
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [4:0]  bus_addr,
  input  logic [31:0] bus_wdata,
  input  logic        bus_we,
  input  logic        bus_re,
  output logic [31:0] bus_rdata,
  output logic [31:0] nn_arg,
  input  logic [31:0] nn_data,
  input  logic        nn_en,
  output logic        busy
);

  nn_state_e  state;
  logic [2:0] reg_sel;
  logic       ctrl_wr;
  logic       clr_wr;
  logic       rd_result;
  logic       new_resize;
  logic       new_bin;

  // Configuration
  logic             auto_q;
  logic             resize_q;
  logic             bin_q;
  logic [CNT_W-1:0] period_q;
  logic [CNT_W-1:0] timeout_q;

  // Sequencer
  logic             oneshot_pend;
  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] gap_cnt;
  logic [15:0]      tmo_cnt;

  // Result side
  logic             ovf_q;
  logic             ufl_q;
  logic [31:0]      last_q;
  logic [CNT_W-1:0] infer_cnt;
  logic [31:0]      status;
  logic [31:0]      rd_mux;

  logic                          fifo_full;
  logic                          fifo_empty;
  logic [31:0]                   fifo_data;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;

  logic unused_addr;
  assign unused_addr = ^bus_addr[1:0];

  assign reg_sel    = bus_addr[4:2];
  assign ctrl_wr    = bus_we && (reg_sel == REG_CTRL);
  assign clr_wr     = bus_we && (reg_sel == REG_CLEAR) && bus_wdata[0];
  assign rd_result  = bus_re && (reg_sel == REG_RESULT);
  // A CTRL write is reflected in nn_arg on the very next edge, including a start word.
  assign new_resize = ctrl_wr ? bus_wdata[CTRL_RESIZE] : resize_q;
  assign new_bin    = ctrl_wr ? bus_wdata[CTRL_BIN]    : bin_q;
  assign busy       = (state != S_IDLE);

  always_ff @(posedge CLK) begin
    if (RST) begin
      auto_q    <= 1'b0;
      resize_q  <= 1'b0;
      bin_q     <= 1'b0;
      period_q  <= '0;
      timeout_q <= '0;
    end else if (bus_we) begin
      case (reg_sel)
        REG_CTRL: begin
          auto_q   <= bus_wdata[CTRL_AUTO];
          resize_q <= bus_wdata[CTRL_RESIZE];
          bin_q    <= bus_wdata[CTRL_BIN];
        end
        REG_PERIOD:  period_q  <= CNT_W'(bus_wdata);
        REG_TIMEOUT: timeout_q <= CNT_W'(bus_wdata);
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= S_IDLE;
      nn_arg       <= '0;
      oneshot_pend <= 1'b0;
      wait_cnt     <= '0;
      gap_cnt      <= '0;
      tmo_cnt      <= '0;
    end else begin
      nn_arg <= arg_word(new_bin, new_resize, state == S_START, (state == S_START) || ctrl_wr);
      case (state)
        S_IDLE: begin
          if (oneshot_pend || auto_q) state <= S_START;
        end
        S_START: begin
          oneshot_pend <= 1'b0;
          wait_cnt     <= CNT_W'(1);
          state        <= S_WAIT;
        end
        S_WAIT: begin
          if (nn_en) begin
            gap_cnt <= period_q;
            state   <= S_GAP;
          end else if ((timeout_q != '0) && (wait_cnt == timeout_q)) begin
            if (tmo_cnt != '1) tmo_cnt <= tmo_cnt + 16'd1;
            state <= S_START;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        S_GAP: begin
          // PERIOD idle cycles, with PERIOD=0 still spending one cycle here.
          if (gap_cnt <= CNT_W'(1)) state <= auto_q ? S_START : S_IDLE;
          else                      gap_cnt <= gap_cnt - CNT_W'(1);
        end
        default: state <= S_IDLE;
      endcase
      // A fresh oneshot request wins over the clear in S_START.
      if (ctrl_wr && bus_wdata[CTRL_ONESHOT]) oneshot_pend <= 1'b1;
      if (clr_wr) tmo_cnt <= '0;
    end
  end

  nn_result_fifo #(
    .DEPTH(FIFO_DEPTH),
    .W    (32)
  ) u_fifo (
    .clk      (CLK),
    .rst      (RST),
    .push     (nn_en),
    .push_data(nn_data),
    .pop      (rd_result),
    .pop_data (fifo_data),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  always_comb begin
    status                      = '0;
    status[ST_BUSY]             = busy;
    status[ST_EMPTY]            = fifo_empty;
    status[ST_FULL]             = fifo_full;
    status[ST_OVF]              = ovf_q;
    status[ST_UFL]              = ufl_q;
    status[ST_CNT_LSB +: 8]     = 8'(fifo_count);
    status[ST_TMO_LSB +: 16]    = tmo_cnt;
  end

  always_comb begin
    rd_mux = '0;
    case (reg_sel)
      REG_CTRL:      rd_mux = {28'b0, bin_q, resize_q, 1'b0, auto_q};
      REG_PERIOD:    rd_mux = 32'(period_q);
      REG_TIMEOUT:   rd_mux = 32'(timeout_q);
      REG_STATUS:    rd_mux = status;
      REG_RESULT:    rd_mux = fifo_empty ? 32'hFFFF_FFFF : fifo_data;
      REG_LAST:      rd_mux = last_q;
      REG_INFER_CNT: rd_mux = 32'(infer_cnt);
      default:       rd_mux = '0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ovf_q     <= 1'b0;
      ufl_q     <= 1'b0;
      last_q    <= '0;
      infer_cnt <= '0;
      bus_rdata <= '0;
    end else begin
      if (nn_en) begin
        last_q    <= nn_data;
        infer_cnt <= infer_cnt + CNT_W'(1);
        if (fifo_full && !(rd_result && !fifo_empty)) ovf_q <= 1'b1;
      end
      if (rd_result && fifo_empty) ufl_q <= 1'b1;
      if (clr_wr) begin
        ovf_q <= 1'b0;
        ufl_q <= 1'b0;
      end
      if (bus_re) bus_rdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_nn_infer_ctrl.sv
// Self-checking bench for nn_infer_ctrl. Results pushed on nn_en go into a
// scoreboard queue that mirrors the FIFO; RESULT reads pop and compare.
module tb_nn_infer_ctrl;
  localparam int unsigned DEPTH = 4;

  localparam logic [4:0] A_CTRL    = 5'h00;
  localparam logic [4:0] A_PERIOD  = 5'h04;
  localparam logic [4:0] A_TIMEOUT = 5'h08;
  localparam logic [4:0] A_STATUS  = 5'h0C;
  localparam logic [4:0] A_RESULT  = 5'h10;
  localparam logic [4:0] A_LAST    = 5'h14;
  localparam logic [4:0] A_INFER   = 5'h18;
  localparam logic [4:0] A_CLEAR   = 5'h1C;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [4:0]  bus_addr = '0;
  logic [31:0] bus_wdata = '0;
  logic        bus_we = 1'b0;
  logic        bus_re = 1'b0;
  logic [31:0] bus_rdata;
  logic [31:0] nn_arg;
  logic [31:0] nn_data = '0;
  logic        nn_en = 1'b0;
  logic        busy;

  nn_infer_ctrl #(
    .FIFO_DEPTH(DEPTH),
    .CNT_W     (32)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .bus_addr (bus_addr),
    .bus_wdata(bus_wdata),
    .bus_we   (bus_we),
    .bus_re   (bus_re),
    .bus_rdata(bus_rdata),
    .nn_arg   (nn_arg),
    .nn_data  (nn_data),
    .nn_en    (nn_en),
    .busy     (busy)
  );

  always #5 CLK = ~CLK;

  int unsigned cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] sb[$];
  logic        m_ovf = 1'b0;
  logic        m_ufl = 1'b0;
  int          m_tmo = 0;
  logic [31:0] m_last = '0;
  logic [31:0] m_infer = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
    bus_we = 1'b1; bus_addr = a; bus_wdata = d;
    tick();
    bus_we = 1'b0;
  endtask

  task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
    bus_re = 1'b1; bus_addr = a;
    tick();
    bus_re = 1'b0;
    d = bus_rdata;
  endtask

  function automatic void model_push(input logic [31:0] d);
    m_last  = d;
    m_infer = m_infer + 1;
    if (sb.size() < DEPTH) sb.push_back(d);
    else                   m_ovf = 1'b1;
  endfunction

  function automatic void model_reset();
    sb.delete();
    m_ovf = 1'b0; m_ufl = 1'b0; m_tmo = 0; m_last = '0; m_infer = '0;
  endfunction

  function automatic logic [31:0] exp_status(input logic b);
    logic [31:0] s;
    s        = '0;
    s[0]     = b;
    s[1]     = (sb.size() == 0);
    s[2]     = (sb.size() == DEPTH);
    s[3]     = m_ovf;
    s[4]     = m_ufl;
    s[15:8]  = 8'(sb.size());
    s[31:16] = 16'(m_tmo);
    return s;
  endfunction

  task automatic drive_result(input logic [31:0] d);
    nn_en = 1'b1; nn_data = d;
    model_push(d);
    tick();
    nn_en = 1'b0;
  endtask

  task automatic result_read(input string tag);
    logic [31:0] got, exp;
    bus_read(A_RESULT, got);
    if (sb.size() > 0) exp = sb.pop_front();
    else begin
      exp   = 32'hFFFF_FFFF;
      m_ufl = 1'b1;
    end
    check(tag, got, exp);
  endtask

  task automatic status_check(input string tag);
    logic [31:0] got;
    bus_read(A_STATUS, got);
    check(tag, got, exp_status(1'b0));
  endtask

  task automatic reg_check(input string tag, input logic [4:0] a, input logic [31:0] exp);
    logic [31:0] got;
    bus_read(a, got);
    check(tag, got, exp);
  endtask

  task automatic wait_start(input string tag, output int unsigned t);
    int k = 0;
    while (nn_arg !== 32'h3 && k < 200) begin
      tick();
      k++;
    end
    if (k >= 200) check(tag, nn_arg, 32'h3);
    t = cyc;
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (busy !== 1'b0 && k < 200) begin
      tick();
      k++;
    end
    if (k >= 200) check(tag, 32'(busy), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned t0, t1, t2, t3;
    logic [31:0] rd;

    repeat (3) tick();
    RST = 1'b0;
    check("rst_arg", nn_arg, 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    status_check("rst_status");

    // 1: oneshot, start-pulse latency and width, single result
    bus_write(A_CTRL, 32'h2);
    check("t1_we_pulse", nn_arg, 32'h1);
    tick();
    check("t1_busy", 32'(busy), 32'h1);
    tick();
    check("t1_start_lat", nn_arg, 32'h3);
    tick();
    check("t1_start_width", nn_arg, 32'h0);
    drive_result(32'd7);
    tick();
    check("t1_idle", 32'(busy), 32'h0);
    result_read("t1_result");
    status_check("t1_status");

    // 2: auto mode, PERIOD=10, response in the 5th wait cycle
    bus_write(A_PERIOD, 32'd10);
    bus_write(A_CTRL, 32'h1);
    wait_start("t2_start1", t1);
    repeat (4) tick();
    drive_result(32'd1);
    wait_start("t2_start2", t2);
    repeat (4) tick();
    drive_result(32'd2);
    wait_start("t2_start3", t3);
    repeat (4) tick();
    drive_result(32'd3);
    bus_write(A_CTRL, 32'h0);
    wait_idle("t2_idle");
    check("t2_spacing12", t2 - t1, 32'd16);
    check("t2_spacing23", t3 - t2, 32'd16);
    for (int i = 0; i < 3; i++) result_read("t2_result");

    // 3: timeout retry every TIMEOUT+1 cycles
    bus_write(A_TIMEOUT, 32'd20);
    bus_write(A_CTRL, 32'h2);
    wait_start("t3_start1", t0);
    tick();
    wait_start("t3_start2", t1);
    m_tmo++;
    tick();
    wait_start("t3_start3", t2);
    m_tmo++;
    check("t3_retry_a", t1 - t0, 32'd21);
    check("t3_retry_b", t2 - t1, 32'd21);
    bus_read(A_STATUS, rd);
    check("t3_tmo_cnt", 32'(rd[31:16]), 32'(m_tmo));
    drive_result(32'h55);
    wait_idle("t3_idle");
    bus_write(A_TIMEOUT, 32'd0);
    bus_write(A_CLEAR, 32'h1);
    m_tmo = 0;
    result_read("t3_result");
    status_check("t3_status_clr");

    // 4: overflow and underflow
    for (int i = 0; i < 5; i++) drive_result(32'h100 + 32'(i));
    status_check("t4_status_ovf");
    reg_check("t4_last", A_LAST, m_last);
    reg_check("t4_infer", A_INFER, m_infer);
    for (int i = 0; i < 5; i++) result_read("t4_result");
    status_check("t4_status_ufl");
    bus_write(A_CLEAR, 32'h1);
    m_ovf = 1'b0; m_ufl = 1'b0;
    status_check("t4_status_clr");

    // Simultaneous push and pop on a full FIFO
    for (int i = 0; i < 4; i++) drive_result(32'h200 + 32'(i));
    begin
      logic [31:0] exp;
      bus_re = 1'b1; bus_addr = A_RESULT; nn_en = 1'b1; nn_data = 32'h2AA;
      exp = sb.pop_front();
      model_push(32'h2AA);
      tick();
      bus_re = 1'b0; nn_en = 1'b0;
      check("t4_popush_data", bus_rdata, exp);
    end
    status_check("t4_popush_status");
    for (int i = 0; i < 4; i++) result_read("t4_drain");

    // 5: configuration write while idle
    bus_write(A_CTRL, 32'hC);
    check("t5_latch", nn_arg, 32'hD);
    tick();
    check("t5_hold_a", nn_arg, 32'hC);
    tick();
    check("t5_hold_b", nn_arg, 32'hC);
    check("t5_busy", 32'(busy), 32'h0);
    reg_check("t5_ctrl_rd", A_CTRL, 32'hC);
    reg_check("t5_clear_rd", A_CLEAR, 32'h0);
    bus_write(A_CTRL, 32'h0);

    // 6: reset while waiting for a result
    drive_result(32'h77);
    bus_write(A_CTRL, 32'h2);
    wait_start("t6_start", t0);
    tick();
    RST = 1'b1;
    tick();
    check("t6_rst_arg", nn_arg, 32'h0);
    check("t6_rst_busy", 32'(busy), 32'h0);
    RST = 1'b0;
    model_reset();
    status_check("t6_status");
    reg_check("t6_infer", A_INFER, m_infer);
    reg_check("t6_ctrl", A_CTRL, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/nn_infer_ctrl.md
Name: nn_infer_ctrl

Overview:
- Host-side controller for the quantized-CNN wrapper's command/result port.
- Produces the 32-bit `nn_arg` command word (WE, start, resize, binarize) and consumes the `nn_data`/`nn_en` result strobe.
- Sequences single-shot or periodic inferences, with timeout/retry, and buffers results in a small FIFO.
- Exposes everything through a simple word-addressed CPU register port.

Parameters:
- FIFO_DEPTH, 4, result FIFO entries (power of 2, ≥2)
- CNT_W, 32, width of the period, timeout and statistic counters

Ports:
- CLK  in  1  system clock
- RST  in  1  synchronous active-high reset
- bus_addr  in  5  byte address; bits [4:2] select the register
- bus_wdata  in  32  write data
- bus_we  in  1  write strobe, single cycle
- bus_re  in  1  read strobe, single cycle
- bus_rdata  out  32  read data, valid 1 cycle after `bus_re`
- nn_arg  out  32  command word to the CNN wrapper: [0]=WE, [1]=start, [2]=resize, [3]=binarize, [31:4]=0
- nn_data  in  32  prediction from the CNN wrapper
- nn_en  in  1  prediction valid strobe, 1 cycle
- busy  out  1  FSM not in S_IDLE

Behaviour:
- Reset values: all outputs 0; registers 0; FIFO empty; FSM in S_IDLE.
- Registers (byte offsets):
  - 0x00 CTRL (RW except bit1): [0] auto, [1] oneshot (W1S, self-clearing, reads 0), [2] resize, [3] bin.
  - 0x04 PERIOD (RW): idle cycles between auto inferences.
  - 0x08 TIMEOUT (RW): 0 = no timeout.
  - 0x0C STATUS (RO): [0] busy, [1] empty, [2] full, [3] overflow sticky, [4] underflow sticky, [15:8] count, [31:16] timeout count (saturating).
  - 0x10 RESULT (RO, pop on read).
  - 0x14 LAST (RO): most recent `nn_data` accepted.
  - 0x18 INFER_CNT (RO): results received, wrapping.
  - 0x1C: write 1 to bit0 clears the sticky bits and the timeout count; reads 0.
- `nn_arg` is registered. Default value is `{28'b0, bin, resize, 2'b00}`.
- FSM:
  - S_IDLE: if `oneshot_pend` or `auto` → S_START.
  - S_START: lasts 1 cycle.
    - Drives `nn_arg[1:0]` = 2'b11.
    - Clears `oneshot_pend`.
    - Loads the timeout counter.
    - → S_WAIT.
  - S_WAIT:
    - `nn_en` → load gap counter with PERIOD, → S_GAP.
    - Else if TIMEOUT≠0 and the wait counter reaches TIMEOUT → increment timeout count, → S_START (retry).
  - S_GAP: counter decrements.
    - At 0: → S_START if `auto`, else S_IDLE.
    - PERIOD=0 gives 1 cycle in S_GAP.
- Clearing `auto` during S_WAIT or S_GAP takes effect at the next decision point. The in-flight inference completes.
- CTRL write outside S_START: the next cycle drives `nn_arg[0]`=1, `nn_arg[1]`=0 to latch the new resize/bin. If this coincides with S_START, the start word carries the new bits.
- FIFO:
  - Push on every `nn_en`, in any state; late results after a retry are also accepted.
  - Push when full: drop the data and set overflow. LAST and INFER_CNT still update.
  - Pop on `bus_re` to 0x10 when non-empty. Pop on empty: rdata = 32'hFFFF_FFFF and set underflow.
  - Simultaneous push and pop when full: both happen, count unchanged, no overflow.
- Latency: `nn_arg` start pulse appears 2 cycles after a oneshot write (write→S_IDLE decision→S_START register).
- Bus reads: unmapped reads return 0, writes to RO registers are ignored, and `bus_we` and `bus_re` in the same cycle are both honoured.
- Reset mid-operation: FSM to S_IDLE; `nn_arg` is 0 the following cycle; FIFO is flushed.

Decomposition:
- Package `nn_ctrl_pkg`:
  - register offset constants
  - `nn_arg` bit-index constants (ARG_WE, ARG_START, ARG_RESIZE, ARG_BIN)
  - FSM state enum
  - STATUS field positions
- Sub-module `nn_result_fifo`: synchronous FIFO with count, full/empty and simultaneous push/pop handling.

Test Plan:
1. Reset, write CTRL=0x2 → `nn_arg`=0x3 for exactly 1 cycle. Drive `nn_en` with `nn_data`=7 → after the 1-cycle S_GAP, busy=0; read RESULT = 7; STATUS count = 0.
2. CTRL=0x1, PERIOD=10, respond to each start 5 cycles later with `nn_data`=1,2,3 → start pulses 16 cycles apart; RESULT reads return 1,2,3 in order.
3. TIMEOUT=20, oneshot, no `nn_en` → start re-issued every 21 cycles; STATUS[31:16] increments.
4. Five results without reads → overflow=1, count=4; RESULT returns the first four; the next read returns 0xFFFFFFFF with underflow=1.
5. Write CTRL=0xC while idle → `nn_arg`=0xD for 1 cycle, then 0xC held.
6. Assert RST during S_WAIT → next cycle `nn_arg`=0, busy=0, STATUS empty=1.
